subset_enumerator: RTL and testbench
====================================

// Module: subset_enumerator
// PURPOSE
//  Generator counterpart to the bit-containment checker, which tests (A & B) == A.
//  Given a mask, this block streams every value S for which (S & mask) == S.
//  Values leave in strictly ascending order, one per accepted valid/ready beat.
//  Used to drive exhaustive sweeps of masked fields and to feed the checker in
//  self-checking loops.
// PARAMETERS
//  WIDTH  32  bit width of mask and generated subsets (>=1)
// PORTS
//  clk         in   1        single clock, all logic on rising edge
//  rst         in   1        synchronous reset, active-high
//  start       in   1        begin enumeration of mask (sampled only in IDLE)
//  mask        in   WIDTH    mask to enumerate; latched on accepted start
//  busy        out  1        high from cycle after accepted start until IDLE
//  out_valid   out  1        out_subset holds a valid subset
//  out_ready   in   1        downstream accepts beat when out_valid & out_ready
//  out_subset  out  WIDTH    current subset of latched mask
//  out_last    out  1        with out_valid: this beat is the final subset (== mask)
//  done        out  1        one-cycle pulse after last beat accepted
//  count       out  WIDTH+1  number of beats accepted in current/last run
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; busy=0, out_valid=0, out_subset=0,
//   out_last=0, done=0, count=0, latched mask=0. Reset overrides all other inputs.
//  States: IDLE -> EMIT -> DONE -> IDLE.
//  IDLE: start=1 latches mask, sets cur=0, clears count, goes to EMIT.
//   First beat is presented the next cycle: out_valid=1, out_subset=0.
//   The start-to-first-valid latency is 1 cycle.
//  EMIT: out_valid=1, out_subset=cur, out_last=(cur==mask_q), busy=1.
//   Accepted beat (out_valid & out_ready):
//    - count<=count+1.
//    - If cur==mask_q, go to DONE.
//    - Otherwise cur<=(cur - mask_q) & mask_q, computed modulo 2^WIDTH. This
//      yields the next larger subset; there are no gaps and no repeats.
//   No accept (out_ready=0): out_subset, out_last and out_valid hold stable.
//  DONE: out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
//   count holds its final value until the next accepted start or reset.
//  start while not IDLE (EMIT or DONE) is ignored. mask is ignored except
//   at an accepted start.
//  mask=0: exactly one beat (0) with out_last=1; final count=1.
//  mask all-ones: 2^WIDTH beats, so count must reach 2^WIDTH. That is why count
//   is WIDTH+1 bits wide and must never wrap.
//  Total beats for a run = 2^popcount(mask); every beat satisfies
//   (out_subset & mask_q) == out_subset.
//  rst during EMIT aborts the run immediately, with no done pulse; outputs take
//   their reset values on the next cycle.
// TESTING
//  1 mask=32'h0000_000A, start, out_ready=1 -> beats 0,2,8,A; out_last only
//    on A; done pulses the cycle after A is accepted; count=4.
//  2 mask=32'h0000_0000 -> single beat 0 with out_last=1; done pulse; count=1.
//  3 mask=32'h8000_0001, out_ready toggled 1,0,0,1,... -> out_subset stable
//    while stalled; sequence 0,1,8000_0000,8000_0001; count=4.
//  4 start with mask=32'hF during EMIT of mask=32'h3 -> run stays 0,1,2,3 with
//    count=4; the second start has no effect.
//  5 mask=32'hFFFF_FFFF, rst asserted after 3 accepted beats (0,1,2) ->
//    next cycle out_valid=0, busy=0, count=0; no done pulse.
//  6 Random masks with popcount<=12, random out_ready -> scoreboard checks
//    ascending order, containment via the (S&M)==S checker, and
//    count==2^popcount.

Source files
------------

// File: rtl/subset_enumerator.sv
// subset_enumerator: streams every subset S of a latched mask ((S & mask) == S)
// in strictly ascending order over a valid/ready interface, then pulses done.
// The successor of a subset S is ((S - mask) & mask): the subtraction borrows
// through the bits outside the mask, so this behaves like a counter whose
// carries only ripple through mask bits.
module subset_enumerator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mask,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_subset,
    output logic             out_last,
    output logic             done,
    output logic [WIDTH:0]   count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   count_q;

    logic             accept;
    logic             is_last;
    logic [WIDTH-1:0] next_cur;

    // Beat handshake and successor subset; the subtraction wraps modulo 2^WIDTH.
    always_comb begin
        accept   = (state == S_EMIT) && out_ready;
        is_last  = (cur == mask_q);
        next_cur = (cur - mask_q) & mask_q;
    end

    // Control FSM plus the subset cursor and the beat counter.
    // count is one bit wider than the mask so an all-ones mask (2^WIDTH beats)
    // still ends with the exact total instead of wrapping to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mask_q  <= '0;
            cur     <= '0;
            count_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q  <= mask;
                        cur     <= '0;
                        count_q <= '0;
                        state   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (accept) begin
                        count_q <= count_q + {{WIDTH{1'b0}}, 1'b1};
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            cur <= next_cur;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so a stalled beat holds
    // stable until it is accepted.
    always_comb begin
        busy       = (state == S_EMIT);
        out_valid  = (state == S_EMIT);
        out_subset = cur;
        out_last   = (state == S_EMIT) && is_last;
        done       = (state == S_DONE);
        count      = count_q;
    end

endmodule

// File: tb/tb_subset_enumerator.sv
// tb_subset_enumerator: scoreboard bench. Expected beats come from an
// independent bit-deposit model (counter k scattered into the mask bit
// positions) and are queued at start; the monitor pops them as the DUT
// hands out accepted beats.
module tb_subset_enumerator;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  mask = '0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_subset;
    logic          out_last;
    logic          done;
    logic [W:0]    count;

    subset_enumerator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mask       (mask),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_subset (out_subset),
        .out_last   (out_last),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         l;
    } beat_t;

    beat_t        q[$];
    int           n_chk = 0;
    int           n_err = 0;
    int           rdy_mode = 0;
    int           rc = 0;
    int           cyc = 0;
    int           last_acc_cyc = -10;
    int           acc_n = 0;
    logic [W-1:0] mon_mask = '0;
    logic         have_prev = 1'b0;
    logic [W-1:0] prev_s = '0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_s = '0;
    logic         held_l = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ready pattern: 0 always, 1 the 1,0,0 cycle, 2 random, 3 never
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (rc % 3 == 0); rc++; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // monitor: handshakes, stall stability, done timing
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (done) chk("done_gap", 64'(cyc - last_acc_cyc), 64'd1);
        if (stall_prev && out_valid) begin
            chk("stall_subset", {32'b0, out_subset}, {32'b0, held_s});
            chk("stall_last", {63'b0, out_last}, {63'b0, held_l});
        end
        if (!out_valid) have_prev = 1'b0;
        if (out_valid && out_ready && !rst) begin
            acc_n++;
            if (q.size() == 0) begin
                chk("extra_beat", {63'b0, out_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("subset", {32'b0, out_subset}, {32'b0, e.s});
                chk("last", {63'b0, out_last}, {63'b0, e.l});
                chk("contain", {32'b0, out_subset & mon_mask}, {32'b0, out_subset});
                if (have_prev) chk("ascend", {63'b0, out_subset > prev_s}, 64'd1);
                if (e.l) last_acc_cyc = cyc;
            end
            have_prev = 1'b1;
            prev_s    = out_subset;
        end
        stall_prev = out_valid && !out_ready;
        held_s     = out_subset;
        held_l     = out_last;
    end

    // Bit-deposit model: counter k scattered into the mask's set bit positions.
    task automatic push_model(input logic [W-1:0] m);
        int pc;
        int total;
        beat_t b;
        pc = $countones(m);
        total = 1 << pc;
        for (int k = 0; k < total; k++) begin
            int j;
            logic [31:0] kv;
            kv = 32'(k);
            j = 0;
            b.s = '0;
            for (int bi = 0; bi < W; bi++) begin
                if (m[bi]) begin
                    b.s[bi] = kv[j];
                    j++;
                end
            end
            b.l = (k == total - 1);
            q.push_back(b);
        end
    endtask

    task automatic run(input logic [W-1:0] m, input bit inject);
        bit got;
        int pc;
        pc = $countones(m);
        q.delete();
        push_model(m);
        mon_mask = m;
        @(posedge clk); #1;
        start = 1'b1;
        mask  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mask  = $urandom;
        @(negedge clk);
        chk("first_valid", {63'b0, out_valid}, 64'd1);
        chk("first_busy", {63'b0, busy}, 64'd1);
        if (inject) begin
            @(posedge clk); #1;
            start = 1'b1;
            mask  = 32'hF;
            @(posedge clk); #1;
            start = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        chk("done_seen", {63'b0, got}, 64'd1);
        chk("count", {31'b0, count}, 64'd1 << pc);
        chk("q_drained", 64'(q.size()), 64'd0);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        chk("valid_at_done", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        chk("done_one_cycle", {63'b0, done}, 64'd0);
        chk("count_hold", {31'b0, count}, 64'd1 << pc);
    endtask

    initial begin
        bit got;
        bit saw_done;
        int a0;
        beat_t b;
        logic [W-1:0] m;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_subset", {32'b0, out_subset}, 64'd0);
        chk("rst_last", {63'b0, out_last}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_count", {31'b0, count}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: sparse mask, always ready
        rdy_mode = 0;
        run(32'h0000_000A, 1'b0);
        // 2: empty mask -> single beat
        run(32'h0000_0000, 1'b0);
        // 3: stalls with the 1,0,0 ready pattern
        rdy_mode = 1;
        run(32'h8000_0001, 1'b0);
        // 4: start during EMIT is ignored
        run(32'h0000_0003, 1'b1);

        // 5: reset aborts an all-ones run after three beats
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        q.delete();
        for (int k = 0; k < 3; k++) begin
            b.s = 32'(k);
            b.l = 1'b0;
            q.push_back(b);
        end
        mon_mask = 32'hFFFF_FFFF;
        a0 = acc_n;
        @(posedge clk); #1;
        start = 1'b1;
        mask  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (acc_n - a0 >= 3) begin got = 1; break; end
        end
        chk("abort_beats", {63'b0, got}, 64'd1);
        rdy_mode = 3;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_count", {31'b0, count}, 64'd0);
        chk("abort_subset", {32'b0, out_subset}, 64'd0);
        chk("abort_q", 64'(q.size()), 64'd0);
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) saw_done = 1;
            @(negedge clk);
        end
        chk("abort_no_done", {63'b0, saw_done}, 64'd0);

        // 6: random masks, random ready
        rdy_mode = 2;
        for (int t = 0; t < 9; t++) begin
            int pc;
            pc = (t == 8) ? 12 : int'($urandom_range(0, 9));
            m = '0;
            while ($countones(m) < pc) m[$urandom_range(0, W - 1)] = 1'b1;
            run(m, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
